// File: rtl/csr_defs_pkg.sv
// Shared CSR definitions: addresses, op encodings, FSM states
// and mstatus bit positions.
package csr_defs_pkg;

   localparam logic [11:0] CSR_MSTATUS  = 12'h300;
   localparam logic [11:0] CSR_MTVEC    = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH = 12'h340;
   localparam logic [11:0] CSR_MEPC     = 12'h341;
   localparam logic [11:0] CSR_MCAUSE   = 12'h342;
   localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET = 12'hB02;
   localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
   localparam logic [11:0] CSR_MINSTRH  = 12'hB82;
   localparam logic [11:0] CSR_CYCLE    = 12'hC00;
   localparam logic [11:0] CSR_INSTRET  = 12'hC02;
   localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
   localparam logic [11:0] CSR_INSTRH   = 12'hC82;
   localparam logic [11:0] CSR_MHARTID  = 12'hF14;

   typedef enum logic [1:0] {
      CSR_OP_WRITE = 2'b00,
      CSR_OP_SET   = 2'b01,
      CSR_OP_CLEAR = 2'b10,
      CSR_OP_RSVD  = 2'b11
   } csr_op_e;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_REDIRECT = 1'b1
   } csr_state_e;

   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;

endpackage

// File: rtl/csr_unit_if.sv
// CSR access and trap sequencing bundle between the pipeline
// (master) and the CSR unit (slave).
interface csr_unit_if #(parameter int XLEN = 32);

   logic            csr_valid;
   logic            csr_rd_en;
   logic            csr_wr_en;
   logic [1:0]      csr_op;
   logic [11:0]     csr_addr;
   logic [XLEN-1:0] csr_wdata;
   logic            retire;
   logic            trap_req;
   logic [XLEN-1:0] trap_cause;
   logic [XLEN-1:0] trap_pc;
   logic            mret;
   logic [XLEN-1:0] csr_rdata;
   logic            illegal;
   logic            trap_redirect;
   logic [XLEN-1:0] trap_target;
   logic            busy;

   modport master (
      output csr_valid, csr_rd_en, csr_wr_en, csr_op,
      output csr_addr, csr_wdata, retire, trap_req,
      output trap_cause, trap_pc, mret,
      input  csr_rdata, illegal, trap_redirect,
      input  trap_target, busy
   );

   modport slave (
      input  csr_valid, csr_rd_en, csr_wr_en, csr_op,
      input  csr_addr, csr_wdata, retire, trap_req,
      input  trap_cause, trap_pc, mret,
      output csr_rdata, illegal, trap_redirect,
      output trap_target, busy
   );

endinterface

// File: rtl/csr_counter.sv
// Wrapping performance counter with independent lo/hi write ports.
// A write to either half suppresses that cycle's increment.
module csr_counter #(
   parameter int COUNTER_W = 64,
   parameter int XLEN      = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_inc,
   input  logic            i_wr_lo,
   input  logic            i_wr_hi,
   input  logic [XLEN-1:0] i_wdata,
   output logic [XLEN-1:0] o_lo,
   output logic [XLEN-1:0] o_hi
);

   localparam int HW = COUNTER_W - XLEN;

   logic [COUNTER_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_wr_lo) begin
         r_cnt[XLEN-1:0] <= i_wdata;
      end else if (i_wr_hi) begin
         r_cnt[COUNTER_W-1:XLEN] <= i_wdata[HW-1:0];
      end else if (i_inc) begin
         r_cnt <= r_cnt + COUNTER_W'(1);
      end
   end

   assign o_lo = r_cnt[XLEN-1:0];
   assign o_hi = XLEN'(r_cnt >> XLEN);

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file with cycle/instret counters and the
// trap-entry / MRET redirect sequencer.
module csr_unit
   import csr_defs_pkg::*;
#(
   parameter int              XLEN        = 32,
   parameter int              COUNTER_W   = 64,
   parameter logic [XLEN-1:0] MTVEC_RESET = '0,
   parameter logic [XLEN-1:0] MHARTID     = '0
) (
   input logic       clk,
   input logic       rst,
   csr_unit_if.slave bus
);

   localparam logic [XLEN-1:0] ALIGN = {{(XLEN-2){1'b1}}, 2'b00};

   csr_state_e      r_state;
   logic            r_redirect;
   logic [XLEN-1:0] r_target;
   logic            r_mie;
   logic            r_mpie;
   logic [XLEN-1:0] r_mtvec;
   logic [XLEN-1:0] r_mscratch;
   logic [XLEN-1:0] r_mepc;
   logic [XLEN-1:0] r_mcause;

   logic            w_idle;
   logic            w_valid;
   logic            w_hit;
   logic            w_illegal;
   logic            w_wr;
   logic            w_trap;
   logic            w_mret;
   logic [XLEN-1:0] w_old;
   logic [XLEN-1:0] w_new;
   logic [XLEN-1:0] w_cyc_lo;
   logic [XLEN-1:0] w_cyc_hi;
   logic [XLEN-1:0] w_ins_lo;
   logic [XLEN-1:0] w_ins_hi;

   assign w_idle  = (r_state == ST_IDLE);
   assign w_valid = bus.csr_valid & w_idle;
   assign w_trap  = w_idle & bus.trap_req;
   assign w_mret  = w_idle & bus.mret & ~bus.trap_req;

   always_comb begin
      w_hit = 1'b1;
      w_old = '0;
      unique case (bus.csr_addr)
         CSR_MSTATUS: begin
            w_old[MSTATUS_MIE]  = r_mie;
            w_old[MSTATUS_MPIE] = r_mpie;
         end
         CSR_MTVEC:               w_old = r_mtvec;
         CSR_MSCRATCH:            w_old = r_mscratch;
         CSR_MEPC:                w_old = r_mepc;
         CSR_MCAUSE:              w_old = r_mcause;
         CSR_MCYCLE, CSR_CYCLE:   w_old = w_cyc_lo;
         CSR_MCYCLEH, CSR_CYCLEH: w_old = w_cyc_hi;
         CSR_MINSTRET, CSR_INSTRET: w_old = w_ins_lo;
         CSR_MINSTRH, CSR_INSTRH:   w_old = w_ins_hi;
         CSR_MHARTID:             w_old = MHARTID;
         default:                 w_hit = 1'b0;
      endcase
   end

   always_comb begin
      w_new = bus.csr_wdata;
      case (bus.csr_op)
         CSR_OP_SET:   w_new = w_old | bus.csr_wdata;
         CSR_OP_CLEAR: w_new = w_old & ~bus.csr_wdata;
         default:      ;
      endcase
   end

   assign w_illegal = w_valid & (~w_hit
                    | (bus.csr_op == CSR_OP_RSVD)
                    | (bus.csr_wr_en & (bus.csr_addr[11:10] == 2'b11)));

   // A trap taken this cycle squashes the CSR write.
   assign w_wr = w_valid & bus.csr_wr_en & ~w_illegal & ~bus.trap_req;

   csr_counter #(.COUNTER_W(COUNTER_W), .XLEN(XLEN)) u_mcycle (
      .clk     (clk),
      .rst     (rst),
      .i_inc   (1'b1),
      .i_wr_lo (w_wr & (bus.csr_addr == CSR_MCYCLE)),
      .i_wr_hi (w_wr & (bus.csr_addr == CSR_MCYCLEH)),
      .i_wdata (w_new),
      .o_lo    (w_cyc_lo),
      .o_hi    (w_cyc_hi)
   );

   csr_counter #(.COUNTER_W(COUNTER_W), .XLEN(XLEN)) u_minstret (
      .clk     (clk),
      .rst     (rst),
      .i_inc   (bus.retire),
      .i_wr_lo (w_wr & (bus.csr_addr == CSR_MINSTRET)),
      .i_wr_hi (w_wr & (bus.csr_addr == CSR_MINSTRH)),
      .i_wdata (w_new),
      .o_lo    (w_ins_lo),
      .o_hi    (w_ins_hi)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mie      <= 1'b0;
         r_mpie     <= 1'b0;
         r_mtvec    <= MTVEC_RESET & ALIGN;
         r_mscratch <= '0;
         r_mepc     <= '0;
         r_mcause   <= '0;
      end else begin
         if (w_trap) begin
            r_mepc   <= bus.trap_pc & ALIGN;
            r_mcause <= bus.trap_cause;
            r_mpie   <= r_mie;
            r_mie    <= 1'b0;
         end else if (w_mret) begin
            r_mie  <= r_mpie;
            r_mpie <= 1'b1;
         end else if (w_wr && bus.csr_addr == CSR_MSTATUS) begin
            r_mie  <= w_new[MSTATUS_MIE];
            r_mpie <= w_new[MSTATUS_MPIE];
         end
         if (w_wr && bus.csr_addr == CSR_MTVEC)
            r_mtvec <= w_new & ALIGN;
         if (w_wr && bus.csr_addr == CSR_MSCRATCH)
            r_mscratch <= w_new;
         if (w_wr && bus.csr_addr == CSR_MEPC)
            r_mepc <= w_new & ALIGN;
         if (w_wr && bus.csr_addr == CSR_MCAUSE)
            r_mcause <= w_new;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_redirect <= 1'b0;
         r_target   <= '0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               r_redirect <= 1'b0;
               if (bus.trap_req) begin
                  r_state    <= ST_REDIRECT;
                  r_redirect <= 1'b1;
                  r_target   <= r_mtvec;
               end else if (bus.mret) begin
                  r_state    <= ST_REDIRECT;
                  r_redirect <= 1'b1;
                  r_target   <= r_mepc;
               end
            end
            ST_REDIRECT: begin
               r_state    <= ST_IDLE;
               r_redirect <= 1'b0;
            end
         endcase
      end
   end

   assign bus.csr_rdata = (w_valid & bus.csr_rd_en & ~w_illegal)
                        ? w_old : '0;
   assign bus.illegal       = w_illegal;
   assign bus.trap_redirect = r_redirect;
   assign bus.trap_target   = r_target;
   assign bus.busy          = (r_state == ST_REDIRECT);

endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit: table of CSR accesses plus
// hand-written counter, trap, MRET and reset sequences.
module tb_csr_unit;
   import csr_defs_pkg::*;

   localparam int          XLEN = 32;
   localparam logic [31:0] MTV  = 32'h40;
   localparam logic [31:0] HART = 32'h5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   csr_unit_if #(.XLEN(XLEN)) bus ();

   csr_unit #(
      .XLEN(XLEN), .COUNTER_W(64),
      .MTVEC_RESET(MTV), .MHARTID(HART)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   typedef struct {
      logic        rd;
      logic        wr;
      logic [1:0]  op;
      logic [11:0] addr;
      logic [31:0] wd;
      logic [31:0] er;
      logic        ei;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic cyc(input logic v, input logic rd, input logic wr,
                      input logic [1:0] op, input logic [11:0] a,
                      input logic [31:0] wd, input logic tr,
                      input logic mr, input logic rt);
      @(negedge clk);
      bus.csr_valid = v;
      bus.csr_rd_en = rd;
      bus.csr_wr_en = wr;
      bus.csr_op    = op;
      bus.csr_addr  = a;
      bus.csr_wdata = wd;
      bus.trap_req  = tr;
      bus.mret      = mr;
      bus.retire    = rt;
      #1;
   endtask

   task automatic rd(input logic [11:0] a);
      cyc(1, 1, 0, CSR_OP_SET, a, 0, 0, 0, 0);
   endtask

   initial begin
      bus.csr_valid = 0; bus.csr_rd_en = 0; bus.csr_wr_en = 0;
      bus.csr_op = 0; bus.csr_addr = 0; bus.csr_wdata = 0;
      bus.retire = 0; bus.trap_req = 0; bus.mret = 0;
      bus.trap_cause = 0; bus.trap_pc = 0;

      tbl.push_back('{1, 0, CSR_OP_SET,   12'hF14, 32'h0, HART, 0});
      tbl.push_back('{1, 0, CSR_OP_SET,   12'h305, 32'h0, MTV, 0});
      tbl.push_back('{1, 1, CSR_OP_WRITE, 12'h340, 32'hDEADBEEF, 32'h0, 0});
      tbl.push_back('{1, 1, CSR_OP_SET,   12'h340, 32'hF0, 32'hDEADBEEF, 0});
      tbl.push_back('{1, 1, CSR_OP_CLEAR, 12'h340, 32'h0F, 32'hDEADBEFF, 0});
      tbl.push_back('{1, 0, CSR_OP_SET,   12'h340, 32'h0, 32'hDEADBEF0, 0});
      tbl.push_back('{1, 1, CSR_OP_WRITE, 12'h305, 32'h83, MTV, 0});
      tbl.push_back('{1, 0, CSR_OP_SET,   12'h305, 32'h0, 32'h80, 0});
      tbl.push_back('{1, 1, CSR_OP_WRITE, 12'h341, 32'h107, 32'h0, 0});
      tbl.push_back('{1, 0, CSR_OP_SET,   12'h341, 32'h0, 32'h104, 0});
      tbl.push_back('{1, 1, CSR_OP_WRITE, 12'h300, 32'hFFFFFFFF, 32'h0, 0});
      tbl.push_back('{1, 1, CSR_OP_CLEAR, 12'h300, 32'h80, 32'h88, 0});
      tbl.push_back('{1, 0, CSR_OP_SET,   12'h300, 32'h0, 32'h08, 0});
      tbl.push_back('{1, 1, CSR_OP_WRITE, 12'h342, 32'h7, 32'h0, 0});
      tbl.push_back('{1, 0, CSR_OP_SET,   12'h342, 32'h0, 32'h7, 0});
      tbl.push_back('{1, 1, CSR_OP_WRITE, 12'hC00, 32'h0, 32'h0, 1});
      tbl.push_back('{1, 0, CSR_OP_SET,   12'h7FF, 32'h0, 32'h0, 1});
      tbl.push_back('{1, 1, CSR_OP_RSVD,  12'h340, 32'h0, 32'h0, 1});
      tbl.push_back('{0, 1, CSR_OP_WRITE, 12'h340, 32'hDEADBEF0, 32'h0, 0});
      tbl.push_back('{1, 1, CSR_OP_WRITE, 12'hF14, 32'h1, 32'h0, 1});
      tbl.push_back('{1, 0, CSR_OP_SET,   12'h340, 32'h0, 32'hDEADBEF0, 0});

      // reset state
      @(negedge clk); #1;
      chk("rst_redirect", {31'b0, bus.trap_redirect}, 0);
      chk("rst_busy", {31'b0, bus.busy}, 0);
      chk("rst_target", bus.trap_target, 0);
      chk("rst_rdata", bus.csr_rdata, 0);
      @(negedge clk);
      rst = 1'b0;

      // mcycle counts from the first edge after release
      rd(CSR_MCYCLE);  chk("mcycle_1", bus.csr_rdata, 1);
      rd(CSR_MCYCLE);  chk("mcycle_2", bus.csr_rdata, 2);
      cyc(1, 1, 0, CSR_OP_SET, CSR_MINSTRET, 0, 0, 0, 1);
      chk("minstret_0", bus.csr_rdata, 0);
      cyc(1, 1, 0, CSR_OP_SET, CSR_MINSTRET, 0, 0, 0, 1);
      chk("minstret_1", bus.csr_rdata, 1);
      rd(CSR_INSTRET); chk("instret_2", bus.csr_rdata, 2);

      foreach (tbl[i]) begin
         cyc(1, tbl[i].rd, tbl[i].wr, tbl[i].op, tbl[i].addr,
             tbl[i].wd, 0, 0, 0);
         chk($sformatf("tbl%0d_rdata", i), bus.csr_rdata, tbl[i].er);
         chk($sformatf("tbl%0d_ill", i), {31'b0, bus.illegal},
             {31'b0, tbl[i].ei});
      end

      // counter wrap and write-beats-increment
      cyc(1, 0, 1, CSR_OP_WRITE, CSR_MCYCLE, 32'hFFFFFFFF, 0, 0, 0);
      cyc(1, 0, 1, CSR_OP_WRITE, CSR_MCYCLEH, 32'h0, 0, 0, 0);
      rd(CSR_MCYCLE);  chk("wrap_lo_held", bus.csr_rdata, 32'hFFFFFFFF);
      rd(CSR_MCYCLEH); chk("wrap_hi", bus.csr_rdata, 1);
      rd(CSR_MCYCLE);  chk("wrap_lo", bus.csr_rdata, 1);
      cyc(1, 1, 1, CSR_OP_WRITE, CSR_CYCLE, 32'h0, 0, 0, 0);
      chk("ro_wr_ill", {31'b0, bus.illegal}, 1);
      rd(CSR_CYCLE);   chk("ro_unchanged", bus.csr_rdata, 3);
      rd(CSR_CYCLEH);  chk("cycleh", bus.csr_rdata, 1);
      cyc(1, 0, 1, CSR_OP_WRITE, CSR_MINSTRET, 32'h10, 0, 0, 1);
      rd(CSR_INSTRET); chk("minstret_wr", bus.csr_rdata, 32'h10);

      // trap entry: MIE=1, mtvec=0x80
      bus.trap_pc = 32'h100; bus.trap_cause = 32'hB;
      cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
      chk("trap_pre_busy", {31'b0, bus.busy}, 0);
      cyc(1, 1, 0, CSR_OP_SET, 12'h7FF, 0, 1, 0, 0);
      chk("trap_pulse", {31'b0, bus.trap_redirect}, 1);
      chk("trap_target", bus.trap_target, 32'h80);
      chk("trap_busy", {31'b0, bus.busy}, 1);
      chk("redir_ill_masked", {31'b0, bus.illegal}, 0);
      rd(CSR_MEPC);
      chk("trap_pulse_end", {31'b0, bus.trap_redirect}, 0);
      chk("trap_mepc", bus.csr_rdata, 32'h100);
      rd(CSR_MCAUSE);  chk("trap_mcause", bus.csr_rdata, 32'hB);
      rd(CSR_MSTATUS); chk("trap_mstatus", bus.csr_rdata, 32'h80);

      // mret
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("mret_pulse", {31'b0, bus.trap_redirect}, 1);
      chk("mret_target", bus.trap_target, 32'h100);
      rd(CSR_MSTATUS); chk("mret_mstatus", bus.csr_rdata, 32'h88);

      // trap squashes same-cycle CSR write; held trap_req ignored
      bus.trap_pc = 32'h200; bus.trap_cause = 32'h3;
      cyc(1, 1, 1, CSR_OP_WRITE, CSR_MSCRATCH, 32'h1234, 1, 0, 0);
      chk("tw_rdata", bus.csr_rdata, 32'hDEADBEF0);
      cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
      chk("tw_pulse", {31'b0, bus.trap_redirect}, 1);
      rd(CSR_MSCRATCH);
      chk("tw_one_pulse", {31'b0, bus.trap_redirect}, 0);
      chk("tw_mscratch", bus.csr_rdata, 32'hDEADBEF0);
      rd(CSR_MCAUSE);  chk("tw_mcause", bus.csr_rdata, 32'h3);

      // reset while in REDIRECT
      cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("rr_pulse", {31'b0, bus.trap_redirect}, 1);
      #2 rst = 1'b1;
      #1;
      chk("rr_redirect", {31'b0, bus.trap_redirect}, 0);
      chk("rr_busy", {31'b0, bus.busy}, 0);
      chk("rr_target", bus.trap_target, 0);
      @(negedge clk);
      rst = 1'b0;
      rd(CSR_MTVEC);    chk("rr_mtvec", bus.csr_rdata, MTV);
      rd(CSR_MSCRATCH); chk("rr_mscratch", bus.csr_rdata, 0);
      rd(CSR_MSTATUS);  chk("rr_mstatus", bus.csr_rdata, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
